// File: rtl/tx_data_serializer.sv
// CAN data-field serializer: captures the four transmit data words and DLC on load,
// then shifts the field out MSB-first, one bit per bit_req strobe.
module tx_data_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        abort,
    input  logic        bit_req,
    input  logic [15:0] tx_word0,
    input  logic [15:0] tx_word1,
    input  logic [15:0] tx_word2,
    input  logic [15:0] tx_word3,
    input  logic [3:0]  dlc,
    output logic        tx_bit,
    output logic        busy,
    output logic        done,
    output logic [6:0]  bits_left
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] sreg_q, sreg_d;
    logic [6:0]  bits_left_q, bits_left_d;

    // DLC values above 8 still mean an 8-byte data field.
    function automatic logic [6:0] frame_bits(input logic [3:0] code);
        logic [3:0] len;
        len = (code > 4'd8) ? 4'd8 : code;
        return {len, 3'b000};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        if (abort) begin
            state_d     = ST_IDLE;
            sreg_d      = '0;
            bits_left_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        if (frame_bits(dlc) != 7'd0) begin
                            sreg_d      = {tx_word0, tx_word1, tx_word2, tx_word3};
                            bits_left_d = frame_bits(dlc);
                            state_d     = ST_SHIFT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_req) begin
                        sreg_d      = {sreg_q[62:0], 1'b0};
                        bits_left_d = bits_left_q - 7'd1;
                        if (bits_left_q == 7'd1) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d     = ST_IDLE;
                    bits_left_d = '0;
                end
                default: begin
                    state_d     = ST_IDLE;
                    sreg_d      = '0;
                    bits_left_d = '0;
                end
            endcase
        end
    end

    // Line idles recessive whenever no data bit is being presented.
    always_comb begin
        tx_bit = 1'b1;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                tx_bit = sreg_q[63];
                busy   = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign bits_left = bits_left_q;

endmodule

// File: tb/tb_tx_data_serializer.sv
// Directed bench for tx_data_serializer: full, short, clamped, zero-length,
// abort, reset and ignored-input scenarios.
module tb_tx_data_serializer;

    logic        clk = 1'b0;
    logic        rst, load, abort, bit_req;
    logic [15:0] tx_word0, tx_word1, tx_word2, tx_word3;
    logic [3:0]  dlc;
    logic        tx_bit, busy, done;
    logic [6:0]  bits_left;

    int n_assert = 0;
    int n_fail   = 0;

    tx_data_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .abort    (abort),
        .bit_req  (bit_req),
        .tx_word0 (tx_word0),
        .tx_word1 (tx_word1),
        .tx_word2 (tx_word2),
        .tx_word3 (tx_word3),
        .dlc      (dlc),
        .tx_bit   (tx_bit),
        .busy     (busy),
        .done     (done),
        .bits_left(bits_left)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_txbit"}, tx_bit, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_left"}, bits_left, 7'd0);
    endtask

    task automatic do_load(input logic [15:0] w0, w1, w2, w3, input logic [3:0] code);
        tx_word0 = w0; tx_word1 = w1; tx_word2 = w2; tx_word3 = w3; dlc = code;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Consume bits [first, first+count) of v; gap idle cycles precede each strobe.
    task automatic shift_bits(input string tag, input logic [63:0] v, input int first,
                              input int count, input int total, input int gap);
        for (int i = first; i < first + count; i++) begin
            for (int g = 0; g < gap; g++) step();
            check({tag, "_bit"}, tx_bit, v[63-i]);
            check({tag, "_left"}, bits_left, 64'(total - i));
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_nodone"}, done, 1'b0);
            bit_req = 1'b1;
            step();
            bit_req = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] v;
        rst = 1'b1; load = 1'b0; abort = 1'b0; bit_req = 1'b0;
        tx_word0 = '0; tx_word1 = '0; tx_word2 = '0; tx_word3 = '0; dlc = '0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();

        // Full 8-byte frame, strobes spaced 3 cycles apart.
        v = {16'hA55A, 16'h0102, 16'h8000, 16'hFFFF};
        do_load(16'hA55A, 16'h0102, 16'h8000, 16'hFFFF, 4'd8);
        check("full_load_busy", busy, 1'b1);
        check("full_load_left", bits_left, 7'd64);
        check("full_load_bit", tx_bit, 1'b1);
        shift_bits("full", v, 0, 64, 64, 2);
        check("full_done", done, 1'b1);
        check("full_done_busy", busy, 1'b0);
        check("full_done_left", bits_left, 7'd0);
        check("full_done_txbit", tx_bit, 1'b1);
        step();
        check_idle("full_after");

        // Reset in mid-frame acts like abort.
        do_load(16'h00F0, 16'h1111, 16'h2222, 16'h3333, 4'd8);
        shift_bits("rstmid", {16'h00F0, 16'h1111, 16'h2222, 16'h3333}, 0, 5, 64, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_idle("rstmid");
        for (int i = 0; i < 4; i++) begin
            bit_req = 1'b1;
            step();
            check_idle("rstmid_post");
        end
        bit_req = 1'b0;

        // Single byte; remaining bytes must not leak out.
        v = {16'h3C00, 48'h0};
        do_load(16'h3CFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd1);
        check("short_left", bits_left, 7'd8);
        shift_bits("short", v, 0, 8, 8, 1);
        check("short_done", done, 1'b1);
        check("short_busy", busy, 1'b0);
        step();
        check_idle("short_after");

        // Clamped DLC, then abort out of it.
        do_load(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 4'd12);
        check("clamp_left", bits_left, 7'd64);
        check("clamp_busy", busy, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("clamp_abort");

        // Zero length: done straight after load, bit_req ignored.
        do_load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0);
        check("zero_busy", busy, 1'b0);
        check("zero_done", done, 1'b1);
        check("zero_left", bits_left, 7'd0);
        bit_req = 1'b1;
        step();
        check_idle("zero_after");
        step();
        bit_req = 1'b0;
        check_idle("zero_after2");

        // load+abort together in IDLE: abort wins.
        tx_word0 = 16'hFFFF; dlc = 4'd8; load = 1'b1; abort = 1'b1;
        step();
        load = 1'b0; abort = 1'b0;
        check_idle("ldabort");

        // dlc=4, back-to-back strobes, a load while busy, abort with bit_req.
        v = {16'h1234, 16'h5678, 32'h0};
        do_load(16'h1234, 16'h5678, 16'hAAAA, 16'hBBBB, 4'd4);
        check("abt_left", bits_left, 7'd32);
        shift_bits("abt", v, 0, 5, 32, 0);
        tx_word0 = 16'hFFFF; tx_word1 = 16'hFFFF; dlc = 4'd8;
        load = 1'b1;
        shift_bits("abt_ldbusy", v, 5, 1, 32, 0);
        load = 1'b0;
        shift_bits("abt", v, 6, 14, 32, 0);
        check("abt_bit20", tx_bit, v[63-20]);
        check("abt_left20", bits_left, 7'd12);
        abort = 1'b1; bit_req = 1'b1;
        step();
        abort = 1'b0; bit_req = 1'b0;
        check_idle("abt_idle");
        step();
        check_idle("abt_idle2");
        do_load(16'h1234, 16'h5678, 16'hAAAA, 16'hBBBB, 4'd4);
        check("abt_reload_bit", tx_bit, 1'b0);
        check("abt_reload_left", bits_left, 7'd32);
        shift_bits("abt_reload", v, 0, 32, 32, 0);
        check("abt_reload_done", done, 1'b1);
        step();
        check_idle("abt_reload_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
